// File: rtl/replay_fifo_scheduler_pkg.sv
// Shared types and defaults for the replay FIFO scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default queue count / data width / index width.
package replay_fifo_scheduler_pkg;

   // ARB spends exactly one cycle picking a queue; XFER streams one packet from it.
   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_XFER = 1'b1
   } state_e;

   localparam int DEF_NUM_QUEUES = 4;
   localparam int DEF_DATA_WIDTH = 144;
   localparam int DEF_QSEL_W     = 2;

endpackage : replay_fifo_scheduler_pkg

// File: rtl/replay_fifo_scheduler_rr_arbiter.sv
// Rotating-priority encoder: first requester after last_idx_i, wrapping modulo NUM_QUEUES.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the grant.
// Ports: req_i (request vector), last_idx_i (previous winner),
//        grant_valid_o (any request), grant_idx_o (winning index).
module rr_arbiter
   import replay_fifo_scheduler_pkg::*;
#(
   parameter int NUM_QUEUES = DEF_NUM_QUEUES,
   parameter int QSEL_W     = DEF_QSEL_W
) (
   input  logic [NUM_QUEUES-1:0] req_i,
   input  logic [QSEL_W-1:0]     last_idx_i,
   output logic                  grant_valid_o,
   output logic [QSEL_W-1:0]     grant_idx_o
);

   int idx;

   // Offsets 1..NUM_QUEUES visit every queue once, the previous winner last,
   // so a lone requester is still re-granted.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      idx           = 0;
      for (int off = 1; off <= NUM_QUEUES; off++) begin
         idx = (int'(last_idx_i) + off) % NUM_QUEUES;
         if (!grant_valid_o && req_i[idx]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = QSEL_W'(idx);
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/replay_fifo_scheduler.sv
// Packet-granular round-robin merge of NUM_QUEUES FWFT FIFO read ports onto one stream.
// Latency: FIFO head word to m_tvalid = 1 cycle; one ARB cycle between packets.
// Backpressure: m_tready low holds the output register and suppresses all pops.
// Ports: clk/rst_n; q_dout/q_last/q_empty/q_rd_en/q_enable per-queue FIFO side;
//        m_tdata/m_tlast/m_tvalid/m_tready egress stream; active_q, busy, pkt_count status.
module replay_fifo_scheduler
   import replay_fifo_scheduler_pkg::*;
#(
   parameter int NUM_QUEUES = DEF_NUM_QUEUES,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int QSEL_W     = DEF_QSEL_W
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_dout,
   input  logic [NUM_QUEUES-1:0]            q_last,
   input  logic [NUM_QUEUES-1:0]            q_empty,
   output logic [NUM_QUEUES-1:0]            q_rd_en,
   input  logic [NUM_QUEUES-1:0]            q_enable,
   output logic [DATA_WIDTH-1:0]            m_tdata,
   output logic                             m_tlast,
   output logic                             m_tvalid,
   input  logic                             m_tready,
   output logic [QSEL_W-1:0]                active_q,
   output logic                             busy,
   output logic [31:0]                      pkt_count
);

   state_e                  state_q;
   logic [QSEL_W-1:0]       active_q_q;
   logic [DATA_WIDTH-1:0]   m_tdata_q;
   logic                    m_tlast_q;
   logic                    m_tvalid_q;
   logic [31:0]             pkt_count_q;
   logic [31:0]             pkt_count_d;

   logic [NUM_QUEUES-1:0]   req;
   logic                    grant_vld;
   logic [QSEL_W-1:0]       grant_idx;

   logic                    head_avail;
   logic                    head_last;
   logic [DATA_WIDTH-1:0]   head_data;
   logic                    load;
   logic                    pkt_done;

   // Enable only gates new grants; a packet already in XFER ignores it.
   assign req = q_enable & ~q_empty;

   rr_arbiter #(
      .NUM_QUEUES (NUM_QUEUES),
      .QSEL_W     (QSEL_W)
   ) u_arb (
      .req_i         (req),
      .last_idx_i    (active_q_q),
      .grant_valid_o (grant_vld),
      .grant_idx_o   (grant_idx)
   );

   // Head-of-queue mux for the granted queue.
   always_comb begin
      head_avail = 1'b0;
      head_last  = 1'b0;
      head_data  = '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         if (QSEL_W'(i) == active_q_q) begin
            head_avail = ~q_empty[i];
            head_last  = q_last[i];
            head_data  = q_dout[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // The single output slot may be refilled in the same cycle it drains.
   assign load = (state_q == ST_XFER) && head_avail && (!m_tvalid_q || m_tready);

   // Pop strobe is combinational so the FWFT head advances on the same edge it is captured.
   always_comb begin
      q_rd_en = '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         if (load && (QSEL_W'(i) == active_q_q)) begin
            q_rd_en[i] = 1'b1;
         end
      end
   end

   // Packets are counted at egress handshake, not at pop.
   assign pkt_done    = m_tvalid_q && m_tready && m_tlast_q;
   assign pkt_count_d = pkt_count_q + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ARB;
         active_q_q  <= QSEL_W'(NUM_QUEUES - 1);   // queue 0 wins the first scan
         m_tdata_q   <= '0;
         m_tlast_q   <= 1'b0;
         m_tvalid_q  <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         if (pkt_done) begin
            pkt_count_q <= pkt_count_d;
         end

         if (load) begin
            m_tdata_q  <= head_data;
            m_tlast_q  <= head_last;
            m_tvalid_q <= 1'b1;
         end else if (m_tready) begin
            m_tvalid_q <= 1'b0;
         end

         case (state_q)
            ST_ARB: begin
               if (grant_vld) begin
                  active_q_q <= grant_idx;
                  state_q    <= ST_XFER;
               end
            end
            ST_XFER: begin
               // Leave on loading the last word; an empty head just inserts bubbles.
               if (load && head_last) begin
                  state_q <= ST_ARB;
               end
            end
         endcase
      end
   end

   assign m_tdata   = m_tdata_q;
   assign m_tlast   = m_tlast_q;
   assign m_tvalid  = m_tvalid_q;
   assign active_q  = active_q_q;
   assign busy      = (state_q == ST_XFER);
   assign pkt_count = pkt_count_q;

endmodule : replay_fifo_scheduler

// File: tb/tb_replay_fifo_scheduler.sv
module tb_replay_fifo_scheduler;

   localparam int NQ = 4;
   localparam int W  = 144;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NQ*W-1:0]   q_dout;
   logic [NQ-1:0]     q_last;
   logic [NQ-1:0]     q_empty;
   logic [NQ-1:0]     q_rd_en;
   logic [NQ-1:0]     q_enable = 4'hF;
   logic [W-1:0]      m_tdata;
   logic              m_tlast;
   logic              m_tvalid;
   logic              m_tready = 1'b1;
   logic [1:0]        active_q;
   logic              busy;
   logic [31:0]       pkt_count;

   logic [W:0]        mem [NQ][16];
   int                wr_ptr [NQ];
   int                rd_ptr [NQ];

   logic [W-1:0]      log_dat [$];
   logic              log_last [$];
   logic [1:0]        log_q [$];

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   replay_fifo_scheduler #(
      .NUM_QUEUES (NQ),
      .DATA_WIDTH (W),
      .QSEL_W     (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .q_dout    (q_dout),
      .q_last    (q_last),
      .q_empty   (q_empty),
      .q_rd_en   (q_rd_en),
      .q_enable  (q_enable),
      .m_tdata   (m_tdata),
      .m_tlast   (m_tlast),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .active_q  (active_q),
      .busy      (busy),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   // FWFT FIFO models; flushed while reset is low.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NQ; i++) rd_ptr[i] <= wr_ptr[i];
      end else begin
         for (int i = 0; i < NQ; i++) if (q_rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1;
      end
   end

   always_comb begin
      q_dout  = '0;
      q_last  = '0;
      q_empty = '0;
      for (int i = 0; i < NQ; i++) begin
         q_empty[i] = (rd_ptr[i] == wr_ptr[i]);
         {q_last[i], q_dout[i*W +: W]} = mem[i][rd_ptr[i] % 16];
      end
   end

   // Egress log: word, last flag, and granted queue at handshake.
   always @(posedge clk) begin
      if (rst_n && m_tvalid && m_tready) begin
         log_dat.push_back(m_tdata);
         log_last.push_back(m_tlast);
         log_q.push_back(active_q);
      end
   end

   function automatic logic [W-1:0] wd(input int q, input int p, input int w);
      return {16'hCAFE, 112'd0, 8'(q), 4'(p), 4'(w)};
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      chk("rd_en_onehot0", W'($countones(q_rd_en) <= 1), W'(1));
   endtask

   task automatic push(input int q, input int p, input int w, input logic last);
      mem[q][wr_ptr[q] % 16] = {last, wd(q, p, w)};
      wr_ptr[q]++;
   endtask

   task automatic push_pkt(input int q, input int p, input int len);
      for (int w = 0; w < len; w++) push(q, p, w, (w == len - 1));
   endtask

   task automatic clear_log();
      log_dat.delete();
      log_last.delete();
      log_q.delete();
   endtask

   task automatic wait_pkts(input int n, input string tag);
      int c;
      c = 0;
      while (pkt_count != 32'(n) && c < 300) begin
         step();
         c++;
      end
      chk(tag, W'(pkt_count), W'(n));
   endtask

   task automatic chk_log(input int k, input int q, input int p, input int w,
                          input logic last, input string tag);
      if (k < log_dat.size()) begin
         chk({tag, " dat"},  log_dat[k],     wd(q, p, w));
         chk({tag, " last"}, W'(log_last[k]), W'(last));
         chk({tag, " q"},    W'(log_q[k]),   W'(q));
      end else begin
         chk({tag, " missing"}, W'(log_dat.size()), W'(k + 1));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      q_enable = 4'hF;
      m_tready = 1'b1;
      clear_log();
   endtask

   initial begin
      // ---- reset values
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst q_rd_en",   W'(q_rd_en),   W'(0));
      chk("rst m_tvalid",  W'(m_tvalid),  W'(0));
      chk("rst m_tlast",   W'(m_tlast),   W'(0));
      chk("rst m_tdata",   m_tdata,       W'(0));
      chk("rst active_q",  W'(active_q),  W'(3));
      chk("rst busy",      W'(busy),      W'(0));
      chk("rst pkt_count", W'(pkt_count), W'(0));
      rst_n = 1'b1;
      step();

      // ---- 1: single 3-word packet on Q0
      clear_log();
      push_pkt(0, 0, 3);
      step();
      chk("t1 grant active_q", W'(active_q), W'(0));
      chk("t1 grant busy",     W'(busy),     W'(1));
      for (int k = 0; k < 3; k++) begin
         chk("t1 rd_en", W'(q_rd_en), W'(4'b0001));
         step();
         chk("t1 tvalid", W'(m_tvalid), W'(1));
         chk("t1 tdata",  m_tdata,      wd(0, 0, k));
         chk("t1 tlast",  W'(m_tlast),  W'(k == 2));
      end
      chk("t1 rd_en after last", W'(q_rd_en), W'(0));
      chk("t1 busy after last",  W'(busy),    W'(0));
      step();
      chk("t1 pkt_count", W'(pkt_count), W'(1));
      chk("t1 tvalid off", W'(m_tvalid), W'(0));

      // ---- 2: four 2-word packets, round robin from Q0
      do_reset();
      for (int q = 0; q < NQ; q++) push_pkt(q, 0, 2);
      wait_pkts(4, "t2 pkt_count");
      chk("t2 log size", W'(log_dat.size()), W'(8));
      for (int k = 0; k < 8; k++) chk_log(k, k / 2, 0, k % 2, (k % 2 == 1), "t2");

      // ---- 3: backpressure holds data and pops
      do_reset();
      push_pkt(1, 0, 4);
      step();
      chk("t3 first load rd_en", W'(q_rd_en), W'(4'b0010));
      step();
      m_tready = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("t3 stall rd_en",  W'(q_rd_en),  W'(0));
         chk("t3 stall tdata",  m_tdata,      wd(1, 0, 0));
         chk("t3 stall tvalid", W'(m_tvalid), W'(1));
         step();
      end
      m_tready = 1'b1;
      wait_pkts(1, "t3 pkt_count");
      chk("t3 log size", W'(log_dat.size()), W'(4));
      for (int k = 0; k < 4; k++) chk_log(k, 1, 0, k, (k == 3), "t3");

      // ---- 4: mid-packet gap on Q2 while Q3 waits
      do_reset();
      push(2, 0, 0, 1'b0);
      push(3, 0, 0, 1'b1);
      step();
      chk("t4 grant", W'(active_q), W'(2));
      step();
      for (int k = 0; k < 6; k++) begin
         chk("t4 gap rd_en",    W'(q_rd_en),  W'(0));
         chk("t4 gap busy",     W'(busy),     W'(1));
         chk("t4 gap active_q", W'(active_q), W'(2));
         step();
      end
      push(2, 0, 1, 1'b1);
      wait_pkts(2, "t4 pkt_count");
      chk("t4 log size", W'(log_dat.size()), W'(3));
      chk_log(0, 2, 0, 0, 1'b0, "t4 w0");
      chk_log(1, 2, 0, 1, 1'b1, "t4 w1");
      chk_log(2, 3, 0, 0, 1'b1, "t4 q3");

      // ---- 5: enable mask 1010, then drop Q1 mid-packet
      do_reset();
      q_enable = 4'b1010;
      for (int q = 0; q < NQ; q++) begin
         push_pkt(q, 0, 2);
         push_pkt(q, 1, 2);
      end
      wait_pkts(4, "t5a pkt_count");
      chk("t5a log size", W'(log_dat.size()), W'(8));
      for (int k = 0; k < 8; k++)
         chk_log(k, ((k / 2) % 2 == 0) ? 1 : 3, k / 4, k % 2, (k % 2 == 1), "t5a");
      clear_log();
      push_pkt(1, 2, 3);
      push_pkt(1, 3, 3);
      push_pkt(3, 2, 1);
      push_pkt(3, 3, 1);
      step();
      chk("t5b grant q1", W'(active_q), W'(1));
      chk("t5b busy",     W'(busy),     W'(1));
      q_enable = 4'b1000;
      wait_pkts(7, "t5b pkt_count");
      repeat (10) step();
      chk("t5b pkt_count idle", W'(pkt_count), W'(7));
      chk("t5b busy idle",      W'(busy),      W'(0));
      chk("t5b log size",       W'(log_dat.size()), W'(5));
      for (int k = 0; k < 3; k++) chk_log(k, 1, 2, k, (k == 2), "t5b q1");
      chk_log(3, 3, 2, 0, 1'b1, "t5b q3a");
      chk_log(4, 3, 3, 0, 1'b1, "t5b q3b");

      // ---- 6: reset mid-packet on Q0 (Q0 still holds its two disabled packets)
      q_enable = 4'b0001;
      step();
      chk("t6 grant q0", W'(active_q), W'(0));
      step();
      chk("t6 tvalid pre", W'(m_tvalid), W'(1));
      chk("t6 tdata pre",  m_tdata,      wd(0, 0, 0));
      rst_n = 1'b0;
      #1;
      chk("t6 rst tvalid",    W'(m_tvalid),  W'(0));
      chk("t6 rst rd_en",     W'(q_rd_en),   W'(0));
      chk("t6 rst pkt_count", W'(pkt_count), W'(0));
      chk("t6 rst busy",      W'(busy),      W'(0));
      chk("t6 rst active_q",  W'(active_q),  W'(3));
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      q_enable = 4'hF;
      clear_log();
      push(0, 5, 0, 1'b1);
      push(1, 5, 0, 1'b1);
      wait_pkts(2, "t6 pkt_count");
      chk("t6 log size", W'(log_dat.size()), W'(2));
      chk_log(0, 0, 5, 0, 1'b1, "t6 first");
      chk_log(1, 1, 5, 0, 1'b1, "t6 second");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_replay_fifo_scheduler
